regfile_wb_arbiter: RTL and testbench

- Sequences the single register-file write port between two writeback sources: the ALU result path and the data-memory load-return path.
- Tracks outstanding load destinations in a scoreboard. This stops an ALU write from overtaking an older load to the same register (WAW).
- Honours the memory BUSYWAIT stall.
- Sits between the execute/memory stages and the register-file write port (WRITE, INADDRESS, IN).

---
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// This block decides which writeback source may use the single register-file
// write port in a given cycle. The two sources are the ALU result path and
// the load-return path. A small scoreboard records the destination of every
// outstanding load. An ALU write to one of those registers waits until the
// load data has been written, so a younger ALU result is never overwritten
// by an older load (WAW).
//
// Ports
//   CLK, RESET         rising-edge clock; synchronous active-high reset
//   BUSYWAIT           memory stall; no grants and no scoreboard clears
//   ALU_REQ/ADDR/DATA  ALU writeback request
//   ALU_GNT            combinational grant to the ALU
//   MEM_ISSUE/_ADDR    load issue; reserves its destination register
//   ISSUE_BLOCKED      combinational; the destination is already reserved
//   MEM_REQ/ADDR/DATA  load-return writeback request
//   MEM_GNT            combinational grant to the load-return path
//   WRITE/INADDRESS/IN registered register-file write port
//   PENDING            registered scoreboard, one bit per register
//   PROTOCOL_ERR       sticky; load data returned for a register not pending
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 3,
   parameter int STARVE_LIMIT = 2
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       BUSYWAIT,
   input  logic                       ALU_REQ,
   input  logic [ADDR_WIDTH-1:0]      ALU_ADDR,
   input  logic [DATA_WIDTH-1:0]      ALU_DATA,
   output logic                       ALU_GNT,
   input  logic                       MEM_ISSUE,
   input  logic [ADDR_WIDTH-1:0]      MEM_ISSUE_ADDR,
   output logic                       ISSUE_BLOCKED,
   input  logic                       MEM_REQ,
   input  logic [ADDR_WIDTH-1:0]      MEM_ADDR,
   input  logic [DATA_WIDTH-1:0]      MEM_DATA,
   output logic                       MEM_GNT,
   output logic                       WRITE,
   output logic [ADDR_WIDTH-1:0]      INADDRESS,
   output logic [DATA_WIDTH-1:0]      IN,
   output logic [(1<<ADDR_WIDTH)-1:0] PENDING,
   output logic                       PROTOCOL_ERR
);

   localparam int NREG = 1 << ADDR_WIDTH;
   localparam int CW   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

   logic [NREG-1:0]       pending_reg;
   logic                  write_reg;
   logic [ADDR_WIDTH-1:0] inaddress_reg;
   logic [DATA_WIDTH-1:0] in_reg;
   logic                  protocol_err_reg;
   logic [CW-1:0]         starve_cnt_reg;

   logic mem_ok;
   logic alu_ok;
   logic alu_prio;
   logic issue_accept;

   // Both eligibility terms are gated by RESET. This keeps both grants low
   // while the block is held in reset, even before the state is known.
   assign mem_ok   = MEM_REQ & ~BUSYWAIT & ~RESET;
   assign alu_ok   = ALU_REQ & ~BUSYWAIT & ~RESET & ~pending_reg[ALU_ADDR];
   assign alu_prio = alu_ok & (starve_cnt_reg == STARVE_MAX);

   assign MEM_GNT = mem_ok & ~alu_prio;
   assign ALU_GNT = alu_ok & ~MEM_GNT;

   // A reservation that is being cleared by this cycle's load writeback can
   // be taken again at once. The set has priority, so the bit stays high.
   assign ISSUE_BLOCKED = ~RESET & MEM_ISSUE & pending_reg[MEM_ISSUE_ADDR]
                        & ~(MEM_GNT & (MEM_ADDR == MEM_ISSUE_ADDR));
   assign issue_accept  = ~RESET & MEM_ISSUE & ~ISSUE_BLOCKED;

   // Scoreboard: each bit is updated on its own, and a set beats a clear.
   for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
      always_ff @(posedge CLK) begin
         if (RESET)
            pending_reg[gi] <= 1'b0;
         else if (issue_accept && (MEM_ISSUE_ADDR == ADDR_WIDTH'(gi)))
            pending_reg[gi] <= 1'b1;
         else if (MEM_GNT && (MEM_ADDR == ADDR_WIDTH'(gi)))
            pending_reg[gi] <= 1'b0;
      end
   end

   // Write port. The address and data hold their values when nothing is
   // granted; only WRITE drops.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         write_reg     <= 1'b0;
         inaddress_reg <= '0;
         in_reg        <= '0;
      end else if (MEM_GNT) begin
         write_reg     <= 1'b1;
         inaddress_reg <= MEM_ADDR;
         in_reg        <= MEM_DATA;
      end else if (ALU_GNT) begin
         write_reg     <= 1'b1;
         inaddress_reg <= ALU_ADDR;
         in_reg        <= ALU_DATA;
      end else begin
         write_reg     <= 1'b0;
      end
   end

   // The counter only advances on denials caused by load priority. A stall
   // or a hazard leaves it unchanged.
   always_ff @(posedge CLK) begin
      if (RESET)
         starve_cnt_reg <= '0;
      else if (!ALU_REQ || ALU_GNT)
         starve_cnt_reg <= '0;
      else if (alu_ok && MEM_GNT && (starve_cnt_reg != STARVE_MAX))
         starve_cnt_reg <= starve_cnt_reg + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RESET)
         protocol_err_reg <= 1'b0;
      else if (MEM_GNT && !pending_reg[MEM_ADDR])
         protocol_err_reg <= 1'b1;
   end

   assign WRITE        = write_reg;
   assign INADDRESS    = inaddress_reg;
   assign IN           = in_reg;
   assign PENDING      = pending_reg;
   assign PROTOCOL_ERR = protocol_err_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed bench for regfile_wb_arbiter using its default parameters:
// 8-bit data, 3-bit address and STARVE_LIMIT=2. Each vector sets the inputs
// for one cycle. The combinational grants are checked mid-cycle, and the
// registered outputs are checked just after the following rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   typedef struct {
      logic       rst, bw, areq;
      logic [2:0] aaddr;
      logic [7:0] adata;
      logic       iss;
      logic [2:0] iaddr;
      logic       mreq;
      logic [2:0] maddr;
      logic [7:0] mdata;
      logic       e_agnt, e_mgnt, e_blk, e_wr;
      logic [2:0] e_ia;
      logic [7:0] e_in;
      logic [7:0] e_pend;
      logic       e_perr;
   } vec_t;

   logic       CLK = 1'b0;
   logic       RESET, BUSYWAIT, ALU_REQ, MEM_ISSUE, MEM_REQ;
   logic [2:0] ALU_ADDR, MEM_ISSUE_ADDR, MEM_ADDR, INADDRESS;
   logic [7:0] ALU_DATA, MEM_DATA, IN, PENDING;
   logic       ALU_GNT, MEM_GNT, ISSUE_BLOCKED, WRITE, PROTOCOL_ERR;

   int errors = 0;
   int checks = 0;
   vec_t vecs[$];

   always #5 CLK = ~CLK;

   regfile_wb_arbiter dut (
      .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT),
      .ALU_REQ(ALU_REQ), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_GNT(ALU_GNT),
      .MEM_ISSUE(MEM_ISSUE), .MEM_ISSUE_ADDR(MEM_ISSUE_ADDR), .ISSUE_BLOCKED(ISSUE_BLOCKED),
      .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_GNT(MEM_GNT),
      .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN), .PENDING(PENDING),
      .PROTOCOL_ERR(PROTOCOL_ERR)
   );

   function automatic vec_t mk(
      input logic rst, input logic bw, input logic areq, input logic [2:0] aaddr,
      input logic [7:0] adata, input logic iss, input logic [2:0] iaddr,
      input logic mreq, input logic [2:0] maddr, input logic [7:0] mdata,
      input logic eag, input logic emg, input logic eblk, input logic ewr,
      input logic [2:0] eia, input logic [7:0] ein, input logic [7:0] epend,
      input logic eperr);
      vec_t v;
      v.rst = rst; v.bw = bw; v.areq = areq; v.aaddr = aaddr; v.adata = adata;
      v.iss = iss; v.iaddr = iaddr; v.mreq = mreq; v.maddr = maddr; v.mdata = mdata;
      v.e_agnt = eag; v.e_mgnt = emg; v.e_blk = eblk; v.e_wr = ewr;
      v.e_ia = eia; v.e_in = ein; v.e_pend = epend; v.e_perr = eperr;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step %0d %s: got %0h expected %0h", idx, name, act, exp);
      end
   endtask

   // Drive at the falling edge, check the grants 1ns later, then check the
   // registered outputs 1ns after the next rising edge.
   task automatic run(input vec_t v, input int idx);
      @(negedge CLK);
      RESET = v.rst; BUSYWAIT = v.bw;
      ALU_REQ = v.areq; ALU_ADDR = v.aaddr; ALU_DATA = v.adata;
      MEM_ISSUE = v.iss; MEM_ISSUE_ADDR = v.iaddr;
      MEM_REQ = v.mreq; MEM_ADDR = v.maddr; MEM_DATA = v.mdata;
      #1;
      chk("ALU_GNT", idx, 32'(ALU_GNT), 32'(v.e_agnt));
      chk("MEM_GNT", idx, 32'(MEM_GNT), 32'(v.e_mgnt));
      chk("ISSUE_BLOCKED", idx, 32'(ISSUE_BLOCKED), 32'(v.e_blk));
      @(posedge CLK);
      #1;
      chk("WRITE", idx, 32'(WRITE), 32'(v.e_wr));
      chk("INADDRESS", idx, 32'(INADDRESS), 32'(v.e_ia));
      chk("IN", idx, 32'(IN), 32'(v.e_in));
      chk("PENDING", idx, 32'(PENDING), 32'(v.e_pend));
      chk("PROTOCOL_ERR", idx, 32'(PROTOCOL_ERR), 32'(v.e_perr));
      $display("step %0d: agnt=%0b mgnt=%0b blk=%0b wr=%0b ia=%0d in=%02h pend=%02h perr=%0b",
               idx, v.e_agnt, v.e_mgnt, v.e_blk, WRITE, INADDRESS, IN, PENDING, PROTOCOL_ERR);
   endtask

   initial begin
      RESET = 1'b1; BUSYWAIT = 1'b0; ALU_REQ = 1'b0; ALU_ADDR = '0; ALU_DATA = '0;
      MEM_ISSUE = 1'b0; MEM_ISSUE_ADDR = '0; MEM_REQ = 1'b0; MEM_ADDR = '0; MEM_DATA = '0;

      //           rst bw ar aa    ad     is ia    mr ma    md     ag mg bl wr eia   ein    pend   perr
      // Reset held for two cycles with busy inputs
      vecs.push_back(mk(1, 0, 1, 3'd1, 8'hE1, 1, 3'd2, 1, 3'd4, 8'hE2, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00, 0));
      vecs.push_back(mk(1, 1, 1, 3'd6, 8'hE3, 1, 3'd6, 1, 3'd7, 8'hE4, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00, 0));
      // ALU alone, then idle
      vecs.push_back(mk(0, 0, 1, 3'd3, 8'h5A, 0, 3'd0, 0, 3'd0, 8'h00, 1, 0, 0, 1, 3'd3, 8'h5A, 8'h00, 0));
      vecs.push_back(mk(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 3'd3, 8'h5A, 8'h00, 0));
      // Collision: reg 4 is re-reserved each cycle so the load stays legal
      vecs.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd4, 0, 3'd0, 8'h00, 0, 0, 0, 0, 3'd3, 8'h5A, 8'h10, 0));
      vecs.push_back(mk(0, 0, 1, 3'd1, 8'hA1, 1, 3'd4, 1, 3'd4, 8'hC1, 0, 1, 0, 1, 3'd4, 8'hC1, 8'h10, 0));
      vecs.push_back(mk(0, 0, 1, 3'd1, 8'hA1, 1, 3'd4, 1, 3'd4, 8'hC2, 0, 1, 0, 1, 3'd4, 8'hC2, 8'h10, 0));
      vecs.push_back(mk(0, 0, 1, 3'd1, 8'hA1, 1, 3'd4, 1, 3'd4, 8'hC3, 1, 0, 1, 1, 3'd1, 8'hA1, 8'h10, 0));
      vecs.push_back(mk(0, 0, 1, 3'd2, 8'hA2, 1, 3'd4, 1, 3'd4, 8'hC3, 0, 1, 0, 1, 3'd4, 8'hC3, 8'h10, 0));
      vecs.push_back(mk(0, 0, 1, 3'd2, 8'hA2, 0, 3'd0, 1, 3'd4, 8'hC4, 0, 1, 0, 1, 3'd4, 8'hC4, 8'h00, 0));
      vecs.push_back(mk(0, 0, 1, 3'd2, 8'hA2, 0, 3'd0, 0, 3'd0, 8'h00, 1, 0, 0, 1, 3'd2, 8'hA2, 8'h00, 0));
      // WAW hazard on reg 5
      vecs.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd5, 0, 3'd0, 8'h00, 0, 0, 0, 0, 3'd2, 8'hA2, 8'h20, 0));
      vecs.push_back(mk(0, 0, 1, 3'd5, 8'h77, 0, 3'd0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 3'd2, 8'hA2, 8'h20, 0));
      vecs.push_back(mk(0, 0, 1, 3'd5, 8'h77, 0, 3'd0, 1, 3'd5, 8'h11, 0, 1, 0, 1, 3'd5, 8'h11, 8'h00, 0));
      vecs.push_back(mk(0, 0, 1, 3'd5, 8'h77, 0, 3'd0, 0, 3'd0, 8'h00, 1, 0, 0, 1, 3'd5, 8'h77, 8'h00, 0));
      vecs.push_back(mk(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 3'd5, 8'h77, 8'h00, 0));
      // BUSYWAIT for three cycles; an issue to reg 7 is still accepted
      vecs.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd6, 0, 3'd0, 8'h00, 0, 0, 0, 0, 3'd5, 8'h77, 8'h40, 0));
      vecs.push_back(mk(0, 1, 1, 3'd0, 8'h0F, 0, 3'd0, 1, 3'd6, 8'h66, 0, 0, 0, 0, 3'd5, 8'h77, 8'h40, 0));
      vecs.push_back(mk(0, 1, 1, 3'd0, 8'h0F, 1, 3'd7, 1, 3'd6, 8'h66, 0, 0, 0, 0, 3'd5, 8'h77, 8'hC0, 0));
      vecs.push_back(mk(0, 1, 1, 3'd0, 8'h0F, 0, 3'd0, 1, 3'd6, 8'h66, 0, 0, 0, 0, 3'd5, 8'h77, 8'hC0, 0));
      vecs.push_back(mk(0, 0, 1, 3'd0, 8'h0F, 0, 3'd0, 1, 3'd6, 8'h66, 0, 1, 0, 1, 3'd6, 8'h66, 8'h80, 0));
      vecs.push_back(mk(0, 0, 1, 3'd0, 8'h0F, 0, 3'd0, 0, 3'd0, 8'h00, 1, 0, 0, 1, 3'd0, 8'h0F, 8'h80, 0));
      // Issue to an already-pending reg 2, then the same issue while it clears
      vecs.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 0, 3'd0, 8'h00, 0, 0, 0, 0, 3'd0, 8'h0F, 8'h84, 0));
      vecs.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 0, 3'd0, 8'h00, 0, 0, 1, 0, 3'd0, 8'h0F, 8'h84, 0));
      vecs.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 1, 3'd2, 8'h22, 0, 1, 0, 1, 3'd2, 8'h22, 8'h84, 0));
      vecs.push_back(mk(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 1, 3'd7, 8'h71, 0, 1, 0, 1, 3'd7, 8'h71, 8'h04, 0));
      vecs.push_back(mk(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 1, 3'd2, 8'h23, 0, 1, 0, 1, 3'd2, 8'h23, 8'h00, 0));
      // Load return for a register that is not pending: written, error sticks
      vecs.push_back(mk(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 1, 3'd3, 8'h33, 0, 1, 0, 1, 3'd3, 8'h33, 8'h00, 1));
      vecs.push_back(mk(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 3'd3, 8'h33, 8'h00, 1));

      for (int i = 0; i < vecs.size(); i++)
         run(vecs[i], i);

      // Reset in mid-operation: a reservation and the sticky error are
      // dropped, no write follows the reset edge, and a grant is possible
      // again in the first cycle after reset.
      run(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd1, 0, 3'd0, 8'h00, 0, 0, 0, 0, 3'd3, 8'h33, 8'h02, 1), 100);
      run(mk(1, 0, 1, 3'd4, 8'h44, 1, 3'd6, 1, 3'd1, 8'h12, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00, 0), 101);
      run(mk(0, 0, 1, 3'd4, 8'h44, 0, 3'd0, 0, 3'd0, 8'h00, 1, 0, 0, 1, 3'd4, 8'h44, 8'h00, 0), 102);
      run(mk(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 3'd4, 8'h44, 8'h00, 0), 103);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
